// File: rtl/player_motion_ctrl.sv
// Player motion sequencer: samples WASD on a move tick, proposes a clamped one-step
// move, confirms it with the map/collision resource, then commits or rejects it.
module player_motion_ctrl #(
  parameter int TICK_DIV    = 1000000,
  parameter int STEP        = 4,
  parameter int X_MAX       = 300,
  parameter int Y_MAX       = 220,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       load,
  input  logic [8:0] start_x,
  input  logic [8:0] start_y,
  input  logic       key_w,
  input  logic       key_a,
  input  logic       key_s,
  input  logic       key_d,
  input  logic       map_ack,
  input  logic       map_blocked,
  output logic       map_req,
  output logic [8:0] map_qx,
  output logic [8:0] map_qy,
  output logic [8:0] player_x,
  output logic [8:0] player_y,
  output logic [1:0] facing,
  output logic       moved,
  output logic       bumped
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int OW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [OW-1:0] TMO_LAST  = OW'(ACK_TIMEOUT - 1);
  localparam logic [9:0]    STEP10    = 10'(STEP);
  localparam logic [9:0]    XMAX10    = 10'(X_MAX);
  localparam logic [9:0]    YMAX10    = 10'(Y_MAX);

  typedef enum logic [1:0] {IDLE, WAIT, CHECK} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [OW-1:0] tmo_q, tmo_d;
  logic          req_q, req_d;
  logic [8:0]    qx_q, qx_d, qy_q, qy_d;
  logic [8:0]    px_q, px_d, py_q, py_d;
  logic [1:0]    face_q, face_d;
  logic          moved_q, moved_d;
  logic          bumped_q, bumped_d;

  logic          key_any;
  logic [1:0]    dir;
  logic [8:0]    cand_x, cand_y;
  logic [9:0]    x10, y10;

  // Candidate move: W > A > S > D, one axis only, clamped using 10-bit sums.
  always_comb begin
    key_any = key_w | key_a | key_s | key_d;
    x10     = {1'b0, px_q};
    y10     = {1'b0, py_q};
    cand_x  = px_q;
    cand_y  = py_q;
    if (key_w)      dir = 2'd0;
    else if (key_a) dir = 2'd1;
    else if (key_s) dir = 2'd2;
    else            dir = 2'd3;
    case (dir)
      2'd0:    cand_y = (y10 < STEP10) ? 9'd0 : 9'(y10 - STEP10);
      2'd1:    cand_x = (x10 < STEP10) ? 9'd0 : 9'(x10 - STEP10);
      2'd2:    cand_y = ((y10 + STEP10) > YMAX10) ? 9'(YMAX10) : 9'(y10 + STEP10);
      default: cand_x = ((x10 + STEP10) > XMAX10) ? 9'(XMAX10) : 9'(x10 + STEP10);
    endcase
  end

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    tmo_d    = tmo_q;
    req_d    = req_q;
    qx_d     = qx_q;
    qy_d     = qy_q;
    px_d     = px_q;
    py_d     = py_q;
    face_d   = face_q;
    moved_d  = 1'b0;
    bumped_d = 1'b0;
    if (load) begin
      px_d    = start_x;
      py_d    = start_y;
      tick_d  = '0;
      tmo_d   = '0;
      req_d   = 1'b0;
      state_d = enable ? WAIT : IDLE;
    end else if (!enable) begin
      state_d = IDLE;
      req_d   = 1'b0;
      tick_d  = '0;
      tmo_d   = '0;
    end else begin
      case (state_q)
        IDLE: state_d = WAIT;
        WAIT: begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (key_any) begin
              face_d = dir;
              if (cand_x == px_q && cand_y == py_q) begin
                bumped_d = 1'b1;
              end else begin
                qx_d    = cand_x;
                qy_d    = cand_y;
                req_d   = 1'b1;
                tmo_d   = '0;
                state_d = CHECK;
              end
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        CHECK: begin
          tick_d = '0;
          if (map_ack) begin
            req_d   = 1'b0;
            tmo_d   = '0;
            state_d = WAIT;
            if (!map_blocked) begin
              px_d    = qx_q;
              py_d    = qy_q;
              moved_d = 1'b1;
            end else begin
              bumped_d = 1'b1;
            end
          end else if (tmo_q == TMO_LAST) begin
            req_d    = 1'b0;
            tmo_d    = '0;
            bumped_d = 1'b1;
            state_d  = WAIT;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      tmo_q    <= '0;
      req_q    <= 1'b0;
      qx_q     <= '0;
      qy_q     <= '0;
      px_q     <= '0;
      py_q     <= '0;
      face_q   <= '0;
      moved_q  <= 1'b0;
      bumped_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      tmo_q    <= tmo_d;
      req_q    <= req_d;
      qx_q     <= qx_d;
      qy_q     <= qy_d;
      px_q     <= px_d;
      py_q     <= py_d;
      face_q   <= face_d;
      moved_q  <= moved_d;
      bumped_q <= bumped_d;
    end
  end

  assign map_req  = req_q;
  assign map_qx   = qx_q;
  assign map_qy   = qy_q;
  assign player_x = px_q;
  assign player_y = py_q;
  assign facing   = face_q;
  assign moved    = moved_q;
  assign bumped   = bumped_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed and randomized bench for player_motion_ctrl against a move-level model
// (position, facing) that predicts each step's query and outcome.
module tb_player_motion_ctrl;

  localparam int TICK  = 4;
  localparam int STEP  = 4;
  localparam int XMAX  = 300;
  localparam int YMAX  = 220;
  localparam int TMO   = 15;
  localparam int BOUND = 60;

  logic       clk = 1'b0;
  logic       rst, enable, load;
  logic [8:0] start_x, start_y;
  logic       key_w, key_a, key_s, key_d;
  logic       map_ack, map_blocked;
  logic       map_req;
  logic [8:0] map_qx, map_qy, player_x, player_y;
  logic [1:0] facing;
  logic       moved, bumped;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int mx = 0, my = 0, mface = 0;

  player_motion_ctrl #(
    .TICK_DIV(TICK), .STEP(STEP), .X_MAX(XMAX), .Y_MAX(YMAX), .ACK_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .load(load),
    .start_x(start_x), .start_y(start_y),
    .key_w(key_w), .key_a(key_a), .key_s(key_s), .key_d(key_d),
    .map_ack(map_ack), .map_blocked(map_blocked),
    .map_req(map_req), .map_qx(map_qx), .map_qy(map_qy),
    .player_x(player_x), .player_y(player_y), .facing(facing),
    .moved(moved), .bumped(bumped)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, check_cnt);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Move rules: W > A > S > D, step of STEP clamped to the field.
  task automatic model_cand(input logic [3:0] k, output bit any, output int dir,
                            output int cx, output int cy);
    any = (k != 4'b0);
    cx = mx;
    cy = my;
    if (k[3])      dir = 0;
    else if (k[2]) dir = 1;
    else if (k[1]) dir = 2;
    else           dir = 3;
    if (!any) return;
    case (dir)
      0:       cy = (my < STEP) ? 0 : my - STEP;
      1:       cx = (mx < STEP) ? 0 : mx - STEP;
      2:       cy = (my + STEP > YMAX) ? YMAX : my + STEP;
      default: cx = (mx + STEP > XMAX) ? XMAX : mx + STEP;
    endcase
  endtask

  task automatic set_keys(input logic [3:0] k);
    {key_w, key_a, key_s, key_d} = k;
  endtask

  task automatic do_load(input int x, input int y);
    load = 1'b1;
    start_x = 9'(x);
    start_y = 9'(y);
    @(negedge clk);
    load = 1'b0;
    mx = x;
    my = y;
    chk("load_x", player_x, mx);
    chk("load_y", player_y, my);
  endtask

  task automatic wait_req_or_bump(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!map_req && !bumped && n < BOUND);
    chk("step_bound", (n < BOUND), 1);
  endtask

  // resp: 0 = ack clear, 1 = ack blocked, 2 = never ack.
  task automatic do_step(input logic [3:0] k, input int resp, input int delay);
    bit any;
    int dir, cx, cy, n, cnt;
    bit seen, unstable;
    model_cand(k, any, dir, cx, cy);
    set_keys(k);
    if (!any) begin
      seen = 0;
      repeat (3 * TICK) begin
        @(negedge clk);
        if (map_req || bumped || moved) seen = 1;
      end
      chk("nokey_quiet", seen, 0);
      chk("nokey_x", player_x, mx);
      chk("nokey_y", player_y, my);
      chk("nokey_face", facing, mface);
      return;
    end
    wait_req_or_bump(n);
    mface = dir;
    set_keys(4'b0);
    if (cx == mx && cy == my) begin
      chk("same_bump", bumped, 1);
      chk("same_noreq", map_req, 0);
      chk("same_face", facing, mface);
      chk("same_x", player_x, mx);
      chk("same_y", player_y, my);
      return;
    end
    chk("req", map_req, 1);
    chk("qx", map_qx, cx);
    chk("qy", map_qy, cy);
    chk("face", facing, mface);
    if (resp == 2) begin
      cnt = 0;
      while (map_req && cnt < BOUND) begin
        cnt++;
        @(negedge clk);
      end
      chk("tmo_len", cnt, TMO);
      chk("tmo_bump", bumped, 1);
      chk("tmo_moved", moved, 0);
      chk("tmo_x", player_x, mx);
      chk("tmo_y", player_y, my);
      return;
    end
    unstable = 0;
    repeat (delay) begin
      @(negedge clk);
      if (!map_req || map_qx != 9'(cx) || map_qy != 9'(cy)) unstable = 1;
    end
    chk("req_stable", unstable, 0);
    map_ack = 1'b1;
    map_blocked = (resp == 1);
    @(negedge clk);
    map_ack = 1'b0;
    map_blocked = 1'b0;
    chk("ack_req_drop", map_req, 0);
    if (resp == 0) begin
      mx = cx;
      my = cy;
      chk("commit_moved", moved, 1);
      chk("commit_bump", bumped, 0);
    end else begin
      chk("blocked_bump", bumped, 1);
      chk("blocked_moved", moved, 0);
    end
    chk("pos_x", player_x, mx);
    chk("pos_y", player_y, my);
  endtask

  function automatic int pick(input int max);
    case ($urandom_range(0, 3))
      0:       return $urandom_range(0, STEP);
      1:       return max - $urandom_range(0, STEP);
      2:       return max;
      default: return $urandom_range(0, max);
    endcase
  endfunction

  initial begin
    int n, r;
    bit seen;
    rst = 1'b0; enable = 1'b0; load = 1'b0;
    start_x = '0; start_y = '0;
    set_keys(4'b0);
    map_ack = 1'b0; map_blocked = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_x", player_x, 0);
    chk("rst_y", player_y, 0);
    chk("rst_face", facing, 0);
    chk("rst_req", map_req, 0);
    chk("rst_qx", map_qx, 0);
    chk("rst_qy", map_qy, 0);
    chk("rst_moved", moved, 0);
    chk("rst_bumped", bumped, 0);
    rst = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    do_load(100, 100);
    do_step(4'b0001, 0, 2);
    chk("d_step1", player_x, 104);
    do_step(4'b0001, 0, 2);
    chk("d_step2", player_x, 108);

    do_load(100, 2);
    do_step(4'b1000, 0, 1);
    chk("w_to_zero", player_y, 0);
    do_step(4'b1000, 0, 1);
    chk("w_at_top_face", facing, 0);

    do_load(100, 100);
    do_step(4'b1001, 0, 0);
    chk("wd_y", player_y, 96);
    chk("wd_x", player_x, 100);

    do_load(200, 100);
    do_step(4'b0100, 1, 3);
    chk("a_blocked_x", player_x, 200);
    chk("a_blocked_face", facing, 1);

    do_load(200, 100);
    do_step(4'b0010, 2, 0);

    // enable low parks the block: held keys produce no activity.
    set_keys(4'b0001);
    enable = 1'b0;
    seen = 0;
    repeat (3 * TICK) begin
      @(negedge clk);
      if (map_req || bumped || moved) seen = 1;
    end
    chk("disabled_quiet", seen, 0);
    set_keys(4'b0);
    enable = 1'b1;
    @(negedge clk);

    // load wins over an outstanding query; the late ack is dropped.
    set_keys(4'b0001);
    wait_req_or_bump(n);
    chk("ldchk_req", map_req, 1);
    set_keys(4'b0);
    mface = 3;
    load = 1'b1; start_x = 9'd20; start_y = 9'd40;
    @(negedge clk);
    load = 1'b0;
    mx = 20; my = 40;
    chk("ldchk_req_drop", map_req, 0);
    map_ack = 1'b1;
    @(negedge clk);
    map_ack = 1'b0;
    chk("ldchk_x", player_x, 20);
    chk("ldchk_y", player_y, 40);
    chk("ldchk_moved", moved, 0);
    chk("ldchk_face", facing, 3);

    // async reset in CHECK clears outputs without a clock edge.
    set_keys(4'b1000);
    wait_req_or_bump(n);
    chk("rstchk_req", map_req, 1);
    set_keys(4'b0);
    #2 rst = 1'b0;
    #1;
    chk("arst_req", map_req, 0);
    chk("arst_x", player_x, 0);
    chk("arst_y", player_y, 0);
    chk("arst_face", facing, 0);
    chk("arst_qx", map_qx, 0);
    chk("arst_qy", map_qy, 0);
    @(negedge clk);
    rst = 1'b1;
    mx = 0; my = 0; mface = 0;
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) do_load(pick(XMAX), pick(YMAX));
      r = $urandom_range(0, 9);
      do_step(4'($urandom_range(0, 15)), (r == 0) ? 2 : (r < 4) ? 1 : 0,
              $urandom_range(0, 5));
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
